// File: rtl/booth_seq_datapath.sv
// Sequential radix-2 Booth multiplier: A/M/Q/Q0 datapath plus its sequencer.
// Accepts two signed WIDTH-bit operands on start. Produces the signed
// 2*WIDTH-bit product after WIDTH ARITH/SHIFT iteration pairs.
module booth_seq_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m_in,
    input  logic [WIDTH-1:0]     q_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARITH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg;
    // A and M carry one guard bit so that m_in = -2^(WIDTH-1) negates without overflow
    logic [WIDTH:0]     a_reg;
    logic [WIDTH:0]     m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               q0_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic               done_reg;

    // Sequencer and datapath: capture, add/sub, arithmetic shift, count down
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            m_reg     <= '0;
            q_reg     <= '0;
            q0_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        m_reg     <= {m_in[WIDTH-1], m_in};
                        q_reg     <= q_in;
                        a_reg     <= '0;
                        q0_reg    <= 1'b0;
                        cnt_reg   <= CNT_W'(WIDTH);
                        busy_reg  <= 1'b1;
                        state_reg <= ARITH;
                    end
                end
                ARITH: begin
                    case ({q_reg[0], q0_reg})
                        2'b01:   a_reg <= a_reg + m_reg;
                        2'b10:   a_reg <= a_reg - m_reg;
                        default: a_reg <= a_reg;
                    endcase
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    // {A,Q,Q0} shifts right by one with A's sign bit replicated
                    {a_reg, q_reg, q0_reg} <= {a_reg[WIDTH], a_reg, q_reg};
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= ARITH;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

    // Product is the low WIDTH bits of A concatenated with Q; the guard bit is dropped
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_product
            assign product[WIDTH + gi] = a_reg[gi];
            assign product[gi]         = q_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_booth_seq_datapath.sv
// Bench for booth_seq_datapath: WIDTH=8 vector table and corner sequences,
// and WIDTH=16 random operands checked against signed integer multiplication.
module tb_booth_seq_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic        start8, start16;
    logic [7:0]  m8, q8;
    logic [15:0] m16, q16;
    logic        busy8, done8, busy16, done16;
    logic [15:0] p8;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_seq_datapath #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .m_in(m8), .q_in(q8),
        .busy(busy8), .done(done8), .product(p8)
    );

    booth_seq_datapath #(.WIDTH(16)) dut16 (
        .clk(clk), .clr(clr), .start(start16), .m_in(m16), .q_in(q16),
        .busy(busy16), .done(done16), .product(p16)
    );

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Starts one multiply, scrambles the operand inputs afterwards, and
    // returns the product seen with done plus the edge latency and busy count.
    task automatic run_op(input bit wide, input logic [15:0] m, input logic [15:0] q,
                          output logic [31:0] prod, output int lat, output int bcnt);
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1; m16 = m; q16 = q;
        end else begin
            start8 = 1'b1; m8 = m[7:0]; q8 = q[7:0];
        end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        m8 = 8'($urandom); q8 = 8'($urandom);
        m16 = 16'($urandom); q16 = 16'($urandom);
        lat = -1; bcnt = 0; prod = '0;
        for (int n = 0; n < 200; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (wide ? done16 : done8) begin
                lat = n;
                prod = wide ? p16 : {16'h0, p8};
                break;
            end
            if (wide ? busy16 : busy8) bcnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prod;
        logic [15:0] wm, wq;
        logic [31:0] wexp;
        int lat, bcnt;

        vecs[0] = '{8'd3,    8'hFC, 16'hFFF4};
        vecs[1] = '{8'h80,   8'h80, 16'h4000};
        vecs[2] = '{8'd127,  8'h80, 16'hC080};
        vecs[3] = '{8'd0,    8'hFF, 16'h0000};
        vecs[4] = '{8'hFF,   8'hFF, 16'h0001};
        vecs[5] = '{8'd127,  8'd127, 16'h3F01};
        vecs[6] = '{8'h80,   8'd127, 16'hC080};
        vecs[7] = '{8'd5,    8'd0,  16'h0000};
        vecs[8] = '{8'hF9,   8'd9,  16'hFFC1};

        clr = 1'b1; start8 = 1'b0; start16 = 1'b0;
        m8 = '0; q8 = '0; m16 = '0; q16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy8}, 32'h0);
        check("reset_done", {31'h0, done8}, 32'h0);
        check("reset_product", {16'h0, p8}, 32'h0);
        check("reset_product16", p16, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        // Table-driven WIDTH=8 vectors
        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, {8'h0, vecs[i].m}, {8'h0, vecs[i].q}, prod, lat, bcnt);
            $display("vec %0d: m=%h q=%h product=%h latency=%0d busy=%0d",
                     i, vecs[i].m, vecs[i].q, prod[15:0], lat, bcnt);
            check($sformatf("vec%0d_product", i), prod, {16'h0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd16);
            @(posedge clk); #1;
            check($sformatf("vec%0d_idle_done", i), {31'h0, done8}, 32'h0);
            check($sformatf("vec%0d_held", i), {16'h0, p8}, {16'h0, vecs[i].exp});
        end

        // start pulses during ARITH (edge k+3) and DONE (edge k+17) are ignored
        @(negedge clk);
        start8 = 1'b1; m8 = 8'd3; q8 = 8'hFC;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            start8 = (n == 3 || n == 17);
            m8 = 8'd55; q8 = 8'd77;
            @(posedge clk); #1;
            if (n == 16) begin
                check("busyphase_done", {31'h0, done8}, 32'h1);
                check("busyphase_product", {16'h0, p8}, 32'h0000FFF4);
            end
            if (n == 17) begin
                check("busyphase_idle_busy", {31'h0, busy8}, 32'h0);
                check("busyphase_idle_done", {31'h0, done8}, 32'h0);
            end
            if (n == 18) begin
                check("busyphase_no_capture", {31'h0, busy8}, 32'h0);
                check("busyphase_held", {16'h0, p8}, 32'h0000FFF4);
            end
        end
        @(negedge clk);
        start8 = 1'b0;

        // clr sampled at edge k+7 aborts the multiply
        start8 = 1'b1; m8 = 8'd3; q8 = 8'hFC;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            clr = (n == 7);
            @(posedge clk); #1;
            if (n == 6) check("abort_busy_before", {31'h0, busy8}, 32'h1);
        end
        check("abort_busy", {31'h0, busy8}, 32'h0);
        check("abort_done", {31'h0, done8}, 32'h0);
        check("abort_product", {16'h0, p8}, 32'h0);

        // clr and start together: clr wins, start is dropped
        @(negedge clk);
        clr = 1'b1; start8 = 1'b1; m8 = 8'd5; q8 = 8'd5;
        @(posedge clk); #1;
        check("clr_start_busy", {31'h0, busy8}, 32'h0);
        @(negedge clk);
        clr = 1'b0; start8 = 1'b0;
        @(posedge clk); #1;
        check("clr_start_still_idle", {31'h0, busy8}, 32'h0);
        run_op(1'b0, 16'h00F9, 16'h0009, prod, lat, bcnt);
        check("after_abort_product", prod, 32'h0000FFC1);
        check("after_abort_latency", 32'(lat), 32'd16);
        @(posedge clk); #1;

        // WIDTH=16: corners then random pairs against signed multiplication
        for (int i = 0; i < 28; i++) begin
            case (i)
                0: begin wm = 16'h8000; wq = 16'h8000; end
                1: begin wm = 16'h7FFF; wq = 16'h8000; end
                2: begin wm = 16'h8000; wq = 16'h0001; end
                3: begin wm = 16'h0000; wq = 16'h8000; end
                4: begin wm = 16'h7FFF; wq = 16'h7FFF; end
                5: begin wm = 16'hFFFF; wq = 16'h8000; end
                default: begin wm = 16'($urandom); wq = 16'($urandom); end
            endcase
            wexp = 32'(longint'($signed(wm)) * longint'($signed(wq)));
            run_op(1'b1, wm, wq, prod, lat, bcnt);
            $display("w16 %0d: m=%h q=%h product=%h latency=%0d", i, wm, wq, prod, lat);
            check($sformatf("w16_%0d_product", i), prod, wexp);
            check($sformatf("w16_%0d_latency", i), 32'(lat), 32'd32);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
